// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: per-requester operands in, one
// registered result out.
interface adder_arbiter_if #(parameter int NREQ = 3);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0][63:0]  req_a;
   logic [NREQ-1:0][63:0]  req_b;
   logic [NREQ-1:0]        req_sub;
   logic [NREQ-1:0]        req_ready;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [1:0]             rsp_id;
   logic [63:0]            rsp_sum;
   logic                   rsp_ovf;
   logic [31:0]            op_count;

   modport master (
      output req_valid, req_a, req_b, req_sub, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, op_count
   );
   modport slave (
      input  req_valid, req_a, req_b, req_sub, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, op_count
   );
endinterface

// File: rtl/adder_arbiter.sv
// Three-way round-robin arbiter sharing one 64-bit signed CLA adder, with a
// single-entry result register and a completed-response counter.

module aa_cla4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);
   logic [3:0] w_g, w_p;
   logic [4:0] w_c;

   assign w_g    = i_a & i_b;
   assign w_p    = i_a ^ i_b;
   assign w_c[0] = i_cin;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign o_sum  = w_p ^ w_c[3:0];
   assign o_cout = w_c[4];
endmodule

module aa_cla64 (
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   input  logic        i_cin,
   output logic [63:0] o_sum,
   output logic        o_carry_overflow
);
   logic [16:0] w_c;

   assign w_c[0] = i_cin;
   for (genvar g = 0; g < 16; g++) begin : g_grp
      aa_cla4 u_grp (
         .i_a   (i_a[4*g +: 4]),
         .i_b   (i_b[4*g +: 4]),
         .i_cin (w_c[g]),
         .o_sum (o_sum[4*g +: 4]),
         .o_cout(w_c[g+1])
      );
   end

   // Carry into bit 63 is recovered from that bit's sum and propagate.
   assign o_carry_overflow = w_c[16] ^ o_sum[63] ^ i_a[63] ^ i_b[63];
endmodule

module adder_arbiter #(parameter int NREQ = 3) (
   input  logic             clk,
   input  logic             rst_n,
   adder_arbiter_if.slave   bus
);
   logic [1:0]      r_ptr;
   logic            r_rsp_valid;
   logic [63:0]     r_rsp_sum;
   logic            r_rsp_ovf;
   logic [1:0]      r_rsp_id;
   logic [31:0]     r_op_count;

   logic            w_can_accept;
   logic            w_any;
   logic [1:0]      w_gidx;
   logic [NREQ-1:0] w_grant;
   logic            w_xfer;
   logic            w_consume;
   logic            w_sub;
   logic [63:0]     w_b_eff;
   logic [63:0]     w_sum;
   logic            w_ovf;

   assign w_can_accept = !r_rsp_valid || bus.rsp_ready;
   assign w_any        = |bus.req_valid;
   assign w_consume    = r_rsp_valid && bus.rsp_ready;

   // First valid requester at or after the pointer, wrapping modulo 3.
   always_comb begin
      w_gidx = 2'd0;
      case (r_ptr)
         2'd1: begin
            if      (bus.req_valid[1]) w_gidx = 2'd1;
            else if (bus.req_valid[2]) w_gidx = 2'd2;
            else                       w_gidx = 2'd0;
         end
         2'd2: begin
            if      (bus.req_valid[2]) w_gidx = 2'd2;
            else if (bus.req_valid[0]) w_gidx = 2'd0;
            else                       w_gidx = 2'd1;
         end
         default: begin
            if      (bus.req_valid[0]) w_gidx = 2'd0;
            else if (bus.req_valid[1]) w_gidx = 2'd1;
            else                       w_gidx = 2'd2;
         end
      endcase
   end

   always_comb begin
      w_grant = '0;
      if (rst_n && w_can_accept && w_any)
         w_grant = NREQ'(1) << w_gidx;
   end

   assign w_xfer  = |w_grant;
   assign w_sub   = bus.req_sub[w_gidx];
   assign w_b_eff = w_sub ? ~bus.req_b[w_gidx] : bus.req_b[w_gidx];

   aa_cla64 u_add (
      .i_a              (bus.req_a[w_gidx]),
      .i_b              (w_b_eff),
      .i_cin            (w_sub),
      .o_sum            (w_sum),
      .o_carry_overflow (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr       <= 2'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_sum   <= '0;
         r_rsp_ovf   <= 1'b0;
         r_rsp_id    <= 2'd0;
         r_op_count  <= '0;
      end else begin
         if (w_xfer) begin
            r_ptr       <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_ovf   <= w_ovf;
            r_rsp_id    <= w_gidx;
         end else if (w_consume) begin
            r_rsp_valid <= 1'b0;
         end
         if (w_consume)
            r_op_count <= r_op_count + 32'd1;
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_sum   = r_rsp_sum;
   assign bus.rsp_ovf   = r_rsp_ovf;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.op_count  = r_op_count;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of grants, results and the counter.
module tb_adder_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   adder_arbiter_if #(.NREQ(3)) bus();
   adder_arbiter #(.NREQ(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

   function automatic logic [2:0] ref_grant(input logic [2:0] v, input int ptr, input bit can);
      if (!can) return 3'b000;
      for (int k = 0; k < 3; k++) begin
         int idx;
         idx = (ptr + k) % 3;
         if (v[idx]) return 3'(1 << idx);
      end
      return 3'b000;
   endfunction

   function automatic logic [64:0] ref_op(input logic [63:0] a, input logic [63:0] b, input logic sub);
      logic [63:0] s;
      logic        o;
      s = sub ? a - b : a + b;
      if (sub) o = (a[63] != b[63]) && (s[63] != a[63]);
      else     o = (a[63] == b[63]) && (s[63] != a[63]);
      return {o, s};
   endfunction

   function automatic logic [63:0] rand_op();
      case ($urandom_range(5, 0))
         0: return MAXV;
         1: return MINV;
         2: return 64'd0;
         3: return '1;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   task automatic clear_in();
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_sub   = '0;
      bus.rsp_ready = 1'b1;
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_in();
      bus.req_valid = 3'b111;
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got %b want 000", bus.req_ready); end
      @(posedge clk); #1;
      n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.rsp_valid); end
      n_vec++; if (bus.rsp_sum !== 64'd0 || bus.rsp_id !== 2'd0 || bus.rsp_ovf !== 1'b0) begin
         n_err++; $display("FAIL reset_rsp got sum=%0h id=%0d ovf=%b want 0/0/0", bus.rsp_sum, bus.rsp_id, bus.rsp_ovf); end
      n_vec++; if (bus.op_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.op_count); end
      n_vec++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready2 got %b want 000", bus.req_ready); end
      bus.req_valid = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_add();
      bus.req_valid = 3'b001; bus.req_a[0] = 64'd5; bus.req_b[0] = 64'd7; bus.req_sub[0] = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;
      n_vec++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL add_ready got %b want 001", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin
         n_err++; $display("FAIL add_rsp got v=%b id=%0d want 1/0", bus.rsp_valid, bus.rsp_id); end
      n_vec++; if (bus.rsp_sum !== 64'd12 || bus.rsp_ovf !== 1'b0) begin
         n_err++; $display("FAIL add_sum got %0d ovf=%b want 12/0", bus.rsp_sum, bus.rsp_ovf); end
      @(posedge clk); #1;
      n_vec++; if (bus.op_count !== 32'd1) begin n_err++; $display("FAIL add_count got %0d want 1", bus.op_count); end
      n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_drain got %b want 0", bus.rsp_valid); end
   endtask

   task automatic test_overflow();
      logic [63:0] ta [3];
      logic [63:0] tb [3];
      logic        ts [3];
      logic [63:0] es [3];
      logic        eo [3];
      ta = '{MAXV, MINV, 64'd3};
      tb = '{64'd1, 64'd1, 64'd5};
      ts = '{1'b0, 1'b1, 1'b1};
      es = '{MINV, MAXV, 64'hFFFF_FFFF_FFFF_FFFE};
      eo = '{1'b1, 1'b1, 1'b0};
      bus.rsp_ready = 1'b1;
      bus.req_valid = 3'b010;
      for (int t = 0; t < 3; t++) begin
         bus.req_a[1] = ta[t]; bus.req_b[1] = tb[t]; bus.req_sub[1] = ts[t];
         #1;
         n_vec++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL ovf_ready[%0d] got %b want 010", t, bus.req_ready); end
         @(posedge clk); #1;
         n_vec++; if (bus.rsp_sum !== es[t] || bus.rsp_ovf !== eo[t] || bus.rsp_id !== 2'd1) begin
            n_err++; $display("FAIL ovf_rsp[%0d] got sum=%0h ovf=%b id=%0d want %0h/%b/1", t, bus.rsp_sum, bus.rsp_ovf, bus.rsp_id, es[t], eo[t]); end
      end
      bus.req_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.req_valid = 3'b111;
      for (int c = 0; c < 3; c++) begin
         bus.req_a[c] = 64'(c * 10); bus.req_b[c] = 64'd1;
      end
      for (int c = 0; c < 6; c++) begin
         #1;
         n_vec++; if (bus.req_ready !== 3'(1 << (c % 3))) begin
            n_err++; $display("FAIL rr_grant[%0d] got %b want %b", c, bus.req_ready, 3'(1 << (c % 3))); end
         @(posedge clk); #1;
         n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(c % 3)) begin
            n_err++; $display("FAIL rr_id[%0d] got v=%b id=%0d want 1/%0d", c, bus.rsp_valid, bus.rsp_id, c % 3); end
      end
      bus.req_valid = '0;
      @(posedge clk); #1;
      n_vec++; if (bus.op_count !== 32'd6) begin n_err++; $display("FAIL rr_count got %0d want 6", bus.op_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.req_valid = 3'b001; bus.req_a[0] = 64'd100; bus.req_b[0] = 64'd1; bus.req_sub[0] = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 3'b010; bus.req_a[1] = 64'd1; bus.req_b[1] = 64'd2; bus.req_sub[1] = 1'b0;
      bus.rsp_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 000", c, bus.req_ready); end
         @(posedge clk); #1;
         n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 64'd99 || bus.rsp_id !== 2'd0 || bus.op_count !== 32'd0) begin
            n_err++; $display("FAIL bp_hold[%0d] got v=%b sum=%0d id=%0d cnt=%0d want 1/99/0/0", c, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.op_count); end
      end
      bus.rsp_ready = 1'b1;
      #1;
      n_vec++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL bp_release got %b want 010", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      n_vec++; if (bus.op_count !== 32'd1 || bus.rsp_sum !== 64'd3 || bus.rsp_id !== 2'd1 || bus.rsp_valid !== 1'b1) begin
         n_err++; $display("FAIL bp_next got cnt=%0d sum=%0d id=%0d v=%b want 1/3/1/1", bus.op_count, bus.rsp_sum, bus.rsp_id, bus.rsp_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req_valid = 3'b001; bus.req_a[0] = 64'd1; bus.req_b[0] = 64'd1;
      @(posedge clk); #1;
      bus.req_valid = 3'b010; bus.req_a[1] = 64'd2; bus.req_b[1] = 64'd2;
      @(posedge clk); #1;
      n_vec++; if (bus.op_count !== 32'd1 || bus.rsp_id !== 2'd1) begin
         n_err++; $display("FAIL mid_pre got cnt=%0d id=%0d want 1/1", bus.op_count, bus.rsp_id); end
      bus.rsp_ready = 1'b0;
      bus.req_valid = 3'b101;
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL mid_ready got %b want 000", bus.req_ready); end
      @(posedge clk); #1;
      n_vec++; if (bus.rsp_valid !== 1'b0 || bus.op_count !== 32'd0) begin
         n_err++; $display("FAIL mid_clear got v=%b cnt=%0d want 0/0", bus.rsp_valid, bus.op_count); end
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      #1;
      n_vec++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL mid_first got %b want 001", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 64'd2) begin
         n_err++; $display("FAIL mid_rsp got v=%b id=%0d sum=%0d want 1/0/2", bus.rsp_valid, bus.rsp_id, bus.rsp_sum); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      do_reset();
      force dut.r_op_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_op_count;
      bus.req_valid = 3'b001; bus.req_a[0] = 64'd4; bus.req_b[0] = 64'd4;
      @(posedge clk); #1;
      bus.req_valid = '0;
      n_vec++; if (bus.op_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_hold got %0h want ffffffff", bus.op_count); end
      @(posedge clk); #1;
      n_vec++; if (bus.op_count !== 32'd0) begin n_err++; $display("FAIL wrap got %0h want 0", bus.op_count); end
   endtask

   task automatic test_random();
      logic [2:0]  hv;
      logic [63:0] ha [3];
      logic [63:0] hb [3];
      logic        hs [3];
      int          wait_xf [3];
      int          m_ptr;
      bit          m_vld;
      logic [63:0] m_sum;
      logic        m_ovf;
      logic [1:0]  m_id;
      logic [31:0] m_cnt;
      logic [2:0]  eg;
      logic [64:0] r;
      do_reset();
      hv = '0; m_ptr = 0; m_vld = 0; m_sum = '0; m_ovf = 0; m_id = '0; m_cnt = '0;
      for (int i = 0; i < 3; i++) begin ha[i] = '0; hb[i] = '0; hs[i] = 0; wait_xf[i] = 0; end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            if (!hv[i] && $urandom_range(1, 0) == 1) begin
               hv[i] = 1'b1; ha[i] = rand_op(); hb[i] = rand_op(); hs[i] = 1'($urandom_range(1, 0)); wait_xf[i] = 0;
            end
            bus.req_a[i] = ha[i]; bus.req_b[i] = hb[i]; bus.req_sub[i] = hs[i];
         end
         bus.req_valid = hv;
         bus.rsp_ready = ($urandom_range(3, 0) != 0);
         #1;
         eg = ref_grant(hv, m_ptr, !m_vld || bus.rsp_ready);
         n_vec++; if (bus.req_ready !== eg) begin n_err++; $display("FAIL rnd_grant[%0d] got %b want %b", cyc, bus.req_ready, eg); end
         n_vec++; if (bus.rsp_valid !== m_vld || bus.op_count !== m_cnt) begin
            n_err++; $display("FAIL rnd_state[%0d] got v=%b cnt=%0d want %b/%0d", cyc, bus.rsp_valid, bus.op_count, m_vld, m_cnt); end
         if (m_vld) begin
            n_vec++; if (bus.rsp_sum !== m_sum || bus.rsp_ovf !== m_ovf || bus.rsp_id !== m_id) begin
               n_err++; $display("FAIL rnd_rsp[%0d] got %0h/%b/%0d want %0h/%b/%0d", cyc, bus.rsp_sum, bus.rsp_ovf, bus.rsp_id, m_sum, m_ovf, m_id); end
         end
         if (m_vld && bus.rsp_ready) m_cnt++;
         if (eg != 3'b000) begin
            int g;
            g = eg[0] ? 0 : (eg[1] ? 1 : 2);
            r = ref_op(ha[g], hb[g], hs[g]);
            m_sum = r[63:0]; m_ovf = r[64]; m_id = 2'(g); m_vld = 1;
            m_ptr = (g + 1) % 3;
            n_vec++; if (wait_xf[g] > 2) begin n_err++; $display("FAIL rnd_fair[%0d] req%0d waited %0d transfers want <=2", cyc, g, wait_xf[g]); end
            hv[g] = 1'b0;
            for (int i = 0; i < 3; i++) if (hv[i]) wait_xf[i]++;
         end else if (m_vld && bus.rsp_ready) begin
            m_vld = 0;
         end
         @(posedge clk); #1;
      end
      bus.req_valid = '0;
   endtask

   initial begin
      clear_in();
      test_reset();
      test_single_add();
      test_overflow();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
